// File: rtl/shift_ser_pkg.sv
// Shared types for the serial-out shift controller: FSM state encoding and
// prescaler width helper.
package shift_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // $clog2(div) would collapse to zero bits when div is 1.
  function automatic int prescale_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Bit-period prescaler: tick is high on the enabled cycle where the count
// reaches DIV-1.
module shift_tick_gen
  import shift_ser_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              PW   = prescale_w(DIV);
  localparam logic [PW-1:0]   LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_ser_ctrl.sv
// Serial-out shift controller: valid/ready word load, LSB-first shift at DIV
// clocks per bit, done pulse. Define SHIFT_SER_PARITY_EN for a trailing even-parity bit.
module shift_ser_ctrl
  import shift_ser_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  input  logic                       abort,
  output logic                       ser_out,
  output logic                       ser_valid,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH)-1:0]   bit_cnt
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pre_clr, pre_en, tick;
`ifdef SHIFT_SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  shift_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .en    (pre_en),
    .tick  (tick)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_cnt   = bit_cnt_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    pre_clr   = 1'b0;
    pre_en    = 1'b0;
`ifdef SHIFT_SER_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d   = ST_SHIFT;
          shreg_d   = in_data;
          bit_cnt_d = '0;
          pre_clr   = 1'b1;
`ifdef SHIFT_SER_PARITY_EN
          parity_d  = ^in_data;
`endif
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          pre_clr   = 1'b1;
        end else begin
          pre_en = 1'b1;
          if (tick) begin
            pre_clr = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef SHIFT_SER_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_DONE;
`endif
            end else begin
              shreg_d   = shreg_q >> 1;
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
`ifdef SHIFT_SER_PARITY_EN
      ST_PARITY: begin
        if (abort) begin
          state_d   = ST_IDLE;
          shreg_d   = '0;
          bit_cnt_d = '0;
          pre_clr   = 1'b1;
        end else begin
          pre_en = 1'b1;
          if (tick) begin
            pre_clr = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
`endif
      ST_DONE: begin
        state_d   = ST_IDLE;
        shreg_d   = '0;
        bit_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    ser_valid_d = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
    busy_d      = ser_valid_d;
    done_d      = (state_d == ST_DONE);
    ser_out_d   = 1'b0;
    if (state_d == ST_SHIFT) ser_out_d = shreg_d[0];
`ifdef SHIFT_SER_PARITY_EN
    if (state_d == ST_PARITY) ser_out_d = parity_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SHIFT_SER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SHIFT_SER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_ser_ctrl.sv
// Scoreboard bench for shift_ser_ctrl: randomized words, held valid, aborts and
// a mid-frame reset, checked against a frame-level reference model.
module tb_shift_ser_ctrl;

  localparam int WIDTH = 8;
  localparam int DIV   = 3;
`ifdef SHIFT_SER_PARITY_EN
  localparam int NPAR  = 1;
`else
  localparam int NPAR  = 0;
`endif
  localparam int FRAME = (WIDTH + NPAR) * DIV;
  localparam int CW    = $clog2(WIDTH);

  typedef struct {
    bit is_done;
    bit sbit;
    int cnt;
  } exp_t;

  exp_t sb[$];

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             in_valid = 1'b0;
  logic             abort    = 1'b0;
  logic [WIDTH-1:0] in_data  = '0;
  logic             in_ready, ser_out, ser_valid, busy, done;
  logic [CW-1:0]    bit_cnt;

  int total = 0;
  int bad   = 0;
  int m_pos = -1;
  bit exp_ready  = 1'b1;
  bit exp_active = 1'b0;
  int frames = 0;
  int aborts = 0;

  shift_ser_ctrl #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .abort     (abort),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame of a word: bit b of the word for DIV cycles each, optional parity, then done.
  task automatic push_frame(input logic [WIDTH-1:0] word);
    exp_t e;
    for (int k = 0; k < FRAME; k++) begin
      int b;
      b = k / DIV;
      e.is_done = 1'b0;
      if (b < WIDTH) begin
        e.sbit = word[b];
        e.cnt  = b;
      end else begin
        e.sbit = ^word;
        e.cnt  = WIDTH - 1;
      end
      sb.push_back(e);
    end
    e.is_done = 1'b1;
    e.sbit    = 1'b0;
    e.cnt     = 0;
    sb.push_back(e);
  endtask

  // Monitor: one sample per cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready", in_ready, exp_ready);
        if (ser_valid || done) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: ser_valid=%0b done=%0b expected idle at %0t",
                     ser_valid, done, $time);
          end else begin
            e = sb.pop_front();
            if (e.is_done) begin
              check("done_pulse", done, 1);
              check("done_ser_valid", ser_valid, 0);
              check("done_busy", busy, 0);
              check("done_ser_out", ser_out, 0);
            end else begin
              check("ser_valid", ser_valid, 1);
              check("busy", busy, 1);
              check("done_early", done, 0);
              check("ser_out", ser_out, e.sbit);
              check("bit_cnt", bit_cnt, e.cnt);
            end
          end
        end else if (exp_active) begin
          total++;
          bad++;
          $display("FAIL missing_output: ser_valid=0 done=0 expected frame activity at %0t", $time);
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
    end
  end

  // Driver and reference model.
  initial begin
    logic [WIDTH-1:0] dir [8];
    bit hold;
    bit did_mid_reset;
    int nword;
    dir = '{8'hA5, 8'h01, 8'hFF, 8'h3C, 8'h07, 8'hAA, 8'h00, 8'h80};
    hold = 1'b0;
    did_mid_reset = 1'b0;
    nword = 0;

    #3;
    check("rst_ser_valid", ser_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      #1;
      if (!did_mid_reset && cyc > 600 && m_pos == 3) begin
        in_valid = 1'b0;
        abort    = 1'b0;
        hold     = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_ser_valid", ser_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ser_out", ser_out, 0);
        check("midrst_bit_cnt", bit_cnt, 0);
        sb.delete();
        m_pos = -1;
        exp_ready = 1'b1;
        exp_active = 1'b0;
        did_mid_reset = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        continue;
      end

      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = (nword < 8) ? dir[nword] : WIDTH'($urandom);
      end
      abort = ($urandom_range(0, 59) == 0);

      if (m_pos < 0) begin
        hold = 1'b0;
        if (in_valid) begin
          push_frame(in_data);
          m_pos = 0;
          nword++;
          frames++;
        end
      end else begin
        hold = in_valid;
        if (m_pos < FRAME && abort) begin
          sb.delete();
          m_pos = -1;
          aborts++;
        end else if (m_pos == FRAME) begin
          m_pos = -1;
        end else begin
          m_pos++;
        end
      end
      exp_ready  = (m_pos < 0);
      exp_active = (m_pos >= 0);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
